// File: rtl/result_byte_presenter.sv
// Result FIFO with a push-button byte stepper. Each queued 16-bit result is shown on
// the LEDs low byte first, then high byte. The second button press retires the entry.
module result_byte_presenter #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     btn_level,
  output logic [7:0]               led_out,
  output logic                     phase,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHOW_LO = 2'd1;
  localparam logic [1:0] SHOW_HI = 2'd2;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   btn_edge;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic [1:0]    state_reg;
  logic [1:0]    state_next;

  logic        full;
  logic        push;
  logic        pop;
  logic [15:0] head;

  assign btn_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  assign full      = (count_reg == CW'(DEPTH));
  assign res_ready = ~full;
  assign push      = res_valid & res_ready;
  // The FSM only reaches SHOW_HI with an entry held, so a pop never underflows.
  assign pop       = (state_reg == SHOW_HI) & btn_edge;
  assign head      = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (!push && pop) count_next = count_reg - CW'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = SHOW_LO;
      SHOW_LO: if (btn_edge) state_next = SHOW_HI;
      SHOW_HI: if (btn_edge) state_next = (count_next != '0) ? SHOW_LO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= '0;
      prev_reg     <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], btn_level};
      prev_reg   <= sync_reg[SYNC_STAGES-1];
      count_reg  <= count_next;
      state_reg  <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (res_valid && !res_ready) overflow_reg <= 1'b1;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= res_data;
  end

  always_comb begin
    led_out = 8'h00;
    phase   = 1'b0;
    case (state_reg)
      SHOW_LO: led_out = head[7:0];
      SHOW_HI: begin
        led_out = head[15:8];
        phase   = 1'b1;
      end
      default: led_out = 8'h00;
    endcase
  end

  assign empty    = (state_reg == IDLE);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_result_byte_presenter.sv
// Directed bench for result_byte_presenter: a table of push/press steps with
// hand-computed LED expectations, plus sequences for reset and coincident push/pop.
module tb_result_byte_presenter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] res_data = 16'h0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        btn_level = 1'b0;
  logic [7:0]  led_out;
  logic        phase;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  result_byte_presenter #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .btn_level(btn_level), .led_out(led_out),
    .phase(phase), .empty(empty), .count(count), .overflow(overflow)
  );

  localparam logic KPUSH  = 1'b0;
  localparam logic KPRESS = 1'b1;

  typedef struct {
    logic        kind;
    logic [15:0] data;
    logic [7:0]  led;
    logic        ph;
    logic        emp;
    logic        ovf;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] led, input logic ph,
                           input logic emp, input logic [2:0] cnt, input logic ovf);
    check({name, ".led"},   0, 16'(led_out),   16'(led));
    check({name, ".phase"}, 0, 16'(phase),     16'(ph));
    check({name, ".empty"}, 0, 16'(empty),     16'(emp));
    check({name, ".count"}, 0, 16'(count),     16'(cnt));
    check({name, ".ovf"},   0, 16'(overflow),  16'(ovf));
    check({name, ".ready"}, 0, 16'(res_ready), 16'(cnt != 3'd4));
  endtask

  task automatic push(input logic [15:0] d);
    res_data  = d;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
  endtask

  // Two sync flops plus the edge cycle: the state moves on the third edge after the rise.
  task automatic press();
    btn_level = 1'b1;
    repeat (3) step();
    btn_level = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    tbl[0]  = '{KPUSH,  16'hA55A, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[1]  = '{KPRESS, 16'h0000, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[2]  = '{KPRESS, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{KPUSH,  16'h1111, 8'h11, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[4]  = '{KPUSH,  16'h2222, 8'h11, 1'b0, 1'b0, 1'b0, 3'd2};
    tbl[5]  = '{KPUSH,  16'h3333, 8'h11, 1'b0, 1'b0, 1'b0, 3'd3};
    tbl[6]  = '{KPUSH,  16'h4444, 8'h11, 1'b0, 1'b0, 1'b0, 3'd4};
    tbl[7]  = '{KPUSH,  16'h5555, 8'h11, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[8]  = '{KPRESS, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b1, 3'd4};
    tbl[9]  = '{KPRESS, 16'h0000, 8'h22, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[10] = '{KPRESS, 16'h0000, 8'h22, 1'b1, 1'b0, 1'b1, 3'd3};
    tbl[11] = '{KPRESS, 16'h0000, 8'h33, 1'b0, 1'b0, 1'b1, 3'd2};
    tbl[12] = '{KPRESS, 16'h0000, 8'h33, 1'b1, 1'b0, 1'b1, 3'd2};
    tbl[13] = '{KPRESS, 16'h0000, 8'h44, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[14] = '{KPRESS, 16'h0000, 8'h44, 1'b1, 1'b0, 1'b1, 3'd1};
    tbl[15] = '{KPRESS, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0};

    // Reset applied between clock edges must take effect with no edge at all.
    #2 rst_n = 1'b0;
    #1;
    check_all("t1_reset", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    $display("txn reset-mid-cycle led=%h empty=%b count=%0d", led_out, empty, count);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Empty state one cycle after a push: count is up but display waits a clock.
    push(16'hA55A);
    check("t2_first_cycle_count", 0, 16'(count), 16'd1);
    check("t2_first_cycle_empty", 0, 16'(empty), 16'd1);
    step();
    check("t2_first_cycle_led", 0, 16'(led_out), 16'h005A);
    check("t2_first_cycle_phase", 0, 16'(phase), 16'd0);
    press();
    press();

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].kind == KPUSH) push(tbl[i].data);
      else press();
      step();
      $display("txn %0d %s data=%h led=%h phase=%b empty=%b count=%0d ovf=%b", i,
               (tbl[i].kind == KPUSH) ? "push " : "press", tbl[i].data, led_out, phase, empty, count, overflow);
      check("tbl_led",   i, 16'(led_out),   16'(tbl[i].led));
      check("tbl_phase", i, 16'(phase),     16'(tbl[i].ph));
      check("tbl_empty", i, 16'(empty),     16'(tbl[i].emp));
      check("tbl_count", i, 16'(count),     16'(tbl[i].cnt));
      check("tbl_ovf",   i, 16'(overflow),  16'(tbl[i].ovf));
      check("tbl_ready", i, 16'(res_ready), 16'(tbl[i].cnt != 3'd4));
    end

    // Reset while showing the high byte with three entries queued.
    push(16'hC0DE);
    push(16'hD00D);
    push(16'hF00F);
    step();
    press();
    check_all("t6_before", 8'hC0, 1'b1, 1'b0, 3'd3, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_all("t6_reset", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    $display("txn reset-in-show_hi led=%h empty=%b count=%0d", led_out, empty, count);
    step();
    rst_n = 1'b1;
    step();
    push(16'h1234);
    step();
    check_all("t6_after_push", 8'h34, 1'b0, 1'b0, 3'd1, 1'b0);
    press();
    check_all("t6_after_press", 8'h12, 1'b1, 1'b0, 3'd1, 1'b0);

    // Pop of the last entry in the same cycle as a push: occupancy stays one.
    btn_level = 1'b1;
    step();
    step();
    res_data  = 16'hBEEF;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check_all("t4_coincident", 8'hEF, 1'b0, 1'b0, 3'd1, 1'b0);
    $display("txn push+pop led=%h phase=%b count=%0d", led_out, phase, count);
    btn_level = 1'b0;
    repeat (3) step();
    press();
    check_all("t4_hi", 8'hBE, 1'b1, 1'b0, 3'd1, 1'b0);
    press();
    check_all("t4_drained", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);

    // A press while idle is dropped; a long hold advances exactly once.
    press();
    check_all("t5_idle_press", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    push(16'h5A01);
    step();
    check_all("t5_after_push", 8'h01, 1'b0, 1'b0, 3'd1, 1'b0);
    btn_level = 1'b1;
    repeat (200) step();
    check_all("t5_held", 8'h5A, 1'b1, 1'b0, 3'd1, 1'b0);
    $display("txn held-200 led=%h phase=%b count=%0d", led_out, phase, count);
    btn_level = 1'b0;
    repeat (3) step();
    check_all("t5_release", 8'h5A, 1'b1, 1'b0, 3'd1, 1'b0);
    press();
    check_all("t5_drained", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
